sqrt_iter: RTL and testbench

SQRT_ITER -- requirements
Module: sqrt_iter

---
 rtl/sqrt_iter.sv | 161 ++++++++++++++++
 tb/tb_sqrt_iter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_iter.sv
// Iterative restoring integer square root: one result bit per cycle, IDLE -> CALC -> DONE.
// Optional stuck-at fault injection on start/done/root/rem when FAULT_INJECT_EN is defined.
module sqrt_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   radicand,
    output logic               busy,
    output logic               done,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   rem
);

    localparam int HW = WIDTH / 2;
    localparam int CW = $clog2(HW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH-1:0] rad_w;
    logic [HW-1:0]   root_w;
    logic [HW-1:0]   rem_w;
    logic [HW-1:0]   root_q;
    logic [HW:0]     rem_q;

    logic            start_i;
    logic            done_i;
    logic            last_iter;

    logic [HW+1:0]   t;
    logic [HW+1:0]   trial;
    logic [HW:0]     diff;
    logic            ge;
    logic [HW:0]     rem_nxt;
    logic [HW-1:0]   root_nxt;

    // Working remainder stays below 2^HW until the last step, so only the
    // final result needs the extra bit.
    assign t         = {rem_w, rad_w[WIDTH-1 -: 2]};
    assign trial     = {root_w, 2'b01};
    assign ge        = (t >= trial);
    assign diff      = t[HW:0] - trial[HW:0];
    assign rem_nxt   = ge ? diff : t[HW:0];
    assign root_nxt  = {root_w[HW-2:0], ge};
    assign last_iter = (cnt_q == CW'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done_i = 1'b0;
        case (state_q)
            CALC:    busy   = 1'b1;
            DONE:    done_i = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            rad_w  <= '0;
            root_w <= '0;
            rem_w  <= '0;
            root_q <= '0;
            rem_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cnt_q  <= CW'(HW);
                        rad_w  <= radicand;
                        root_w <= '0;
                        rem_w  <= '0;
                    end
                end
                CALC: begin
                    cnt_q  <= cnt_q - CW'(1);
                    rad_w  <= {rad_w[WIDTH-3:0], 2'b00};
                    root_w <= root_nxt;
                    rem_w  <= rem_nxt[HW-1:0];
                    if (last_iter) begin
                        root_q <= root_nxt;
                        rem_q  <= rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FAULT_INJECT_EN
    logic          stuck_0_start = 1'b0;
    logic          stuck_1_start = 1'b0;
    logic          stuck_0_done  = 1'b0;
    logic          stuck_1_done  = 1'b0;
    logic [HW-1:0] stuck_0_root  = '0;
    logic [HW-1:0] stuck_1_root  = '0;
    logic [HW:0]   stuck_0_rem   = '0;
    logic [HW:0]   stuck_1_rem   = '0;

    initial begin
        $display("register  %m.stuck_0_start input");
        $display("register  %m.stuck_1_start input");
        $display("register  %m.stuck_0_done output");
        $display("register  %m.stuck_1_done output");
    end

    assign start_i = stuck_1_start ? 1'b1 : stuck_0_start ? 1'b0 : start;
    assign done    = stuck_1_done  ? 1'b1 : stuck_0_done  ? 1'b0 : done_i;

    for (genvar i = 0; i < HW; i++) begin : g_root_fi
        initial begin
            $display("register  %m.stuck_0_root[%0d] output", i);
            $display("register  %m.stuck_1_root[%0d] output", i);
        end
        assign root[i] = stuck_1_root[i] ? 1'b1 : stuck_0_root[i] ? 1'b0 : root_q[i];
    end

    for (genvar i = 0; i <= HW; i++) begin : g_rem_fi
        initial begin
            $display("register  %m.stuck_0_rem[%0d] output", i);
            $display("register  %m.stuck_1_rem[%0d] output", i);
        end
        assign rem[i] = stuck_1_rem[i] ? 1'b1 : stuck_0_rem[i] ? 1'b0 : rem_q[i];
    end
`else
    assign start_i = start;
    assign done    = done_i;
    assign root    = root_q;
    assign rem     = rem_q;
`endif

endmodule

// File: tb/tb_sqrt_iter.sv
// Directed bench for sqrt_iter: vector table plus hand-written sequences for
// re-start, back-to-back start, reset abort and reset-time start.
module tb_sqrt_iter;

    localparam int WIDTH = 16;
    localparam int HW    = WIDTH / 2;
    localparam int LAT   = HW + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] radicand;
    logic             busy;
    logic             done;
    logic [HW-1:0]    root;
    logic [HW:0]      rem;

    int total = 0;
    int bad   = 0;

    sqrt_iter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .radicand (radicand),
        .busy     (busy),
        .done     (done),
        .root     (root),
        .rem      (rem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] rad;
        logic [HW-1:0]    root;
        logic [HW:0]      rem;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Pulse start at a negedge and count negedges until done is seen.
    task automatic run_op(input logic [WIDTH-1:0] r, output int n);
        start    = 1'b1;
        radicand = r;
        @(negedge clk);
        start    = 1'b0;
        radicand = '0;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int dones;

        vecs[0]  = '{16'd0,     8'd0,   9'd0};
        vecs[1]  = '{16'd144,   8'd12,  9'd0};
        vecs[2]  = '{16'd143,   8'd11,  9'd22};
        vecs[3]  = '{16'd65535, 8'd255, 9'd510};
        vecs[4]  = '{16'd1,     8'd1,   9'd0};
        vecs[5]  = '{16'd2,     8'd1,   9'd1};
        vecs[6]  = '{16'd3,     8'd1,   9'd2};
        vecs[7]  = '{16'd15,    8'd3,   9'd6};
        vecs[8]  = '{16'd100,   8'd10,  9'd0};
        vecs[9]  = '{16'd16384, 8'd128, 9'd0};
        vecs[10] = '{16'd65025, 8'd255, 9'd0};
        vecs[11] = '{16'd65024, 8'd254, 9'd508};

        rst_n    = 1'b0;
        start    = 1'b0;
        radicand = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_root", int'(root), 0);
        check("rst_rem",  int'(rem),  0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].rad, n);
            check($sformatf("lat[%0d]", i),  n, LAT);
            check($sformatf("root[%0d]", i), int'(root), int'(vecs[i].root));
            check($sformatf("rem[%0d]", i),  int'(rem),  int'(vecs[i].rem));
            check($sformatf("busy_in_done[%0d]", i), int'(busy), 0);
            @(negedge clk);
            check($sformatf("done_pulse[%0d]", i), int'(done), 0);
            check($sformatf("idle_busy[%0d]", i),  int'(busy), 0);
            check($sformatf("hold_root[%0d]", i),  int'(root), int'(vecs[i].root));
        end

        // Re-start during CALC is dropped and a late radicand change has no effect.
        start    = 1'b1;
        radicand = 16'd100;
        @(negedge clk);
        start    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start    = 1'b1;
        radicand = 16'd4;
        @(negedge clk);
        start    = 1'b0;
        wait_done(n);
        check("restart_lat", n + 4, LAT);
        check("restart_root", int'(root), 10);
        check("restart_rem",  int'(rem),  0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("restart_no_second_done", dones, 0);

        // start held high: next accept at the first IDLE edge after DONE.
        start    = 1'b1;
        radicand = 16'd144;
        @(negedge clk);
        wait_done(n);
        check("b2b_first_seen", int'(done), 1);
        @(negedge clk);
        check("b2b_idle_busy", int'(busy), 0);
        check("b2b_idle_done", int'(done), 0);
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("b2b_period", n, HW + 2);
        check("b2b_root", int'(root), 12);
        repeat (2) @(negedge clk);
        check("b2b_stop", int'(busy), 0);

        // Reset in the 4th CALC cycle aborts; no done is ever delivered.
        start    = 1'b1;
        radicand = 16'hFFFF;
        @(negedge clk);
        start    = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_root", int'(root), 0);
        check("abort_rem",  int'(rem),  0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("abort_quiet", dones, 0);
        run_op(16'd9, n);
        check("after_abort_lat",  n, LAT);
        check("after_abort_root", int'(root), 3);
        check("after_abort_rem",  int'(rem),  0);
        @(negedge clk);

        // start sampled while in reset must not launch a computation.
        rst_n    = 1'b0;
        start    = 1'b1;
        radicand = 16'd50;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        check("rst_start_busy", int'(busy), 0);
        @(negedge clk);
        check("rst_start_idle", int'(busy), 0);

`ifdef FAULT_INJECT_EN
        dut.stuck_1_done = 1'b1;
        start    = 1'b1;
        radicand = 16'd144;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 1; i < LAT + 2; i++) begin
            if (!done) dones++;
            if (int'(busy) != ((i < LAT) ? 1 : 0)) dones++;
            @(negedge clk);
        end
        check("fi_done_stuck", dones, 0);
        dut.stuck_1_done  = 1'b0;
        dut.stuck_0_start = 1'b1;
        start = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy) dones++;
        end
        start = 1'b0;
        check("fi_start_stuck0", dones, 0);
        dut.stuck_0_start = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
